// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and lane helpers for the LSU
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Only funct3[1:0] selects the width; the unsigned bit does not change the mask.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] word,
                                                input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (funct3)
            F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
            F3_W:    load_extend = sh;
            F3_BU:   load_extend = {24'd0, sh[7:0]};
            F3_HU:   load_extend = {16'd0, sh[15:0]};
            default: load_extend = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational request check, byte-lane mask, store shift and load extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic        chk_is_store,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_off,
    output logic        err,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic bad_f3;
    logic misal;

    always_comb begin
        bad_f3 = chk_is_store ? (chk_funct3 > F3_W)
                              : (chk_funct3 == 3'b011 || chk_funct3[2:1] == 2'b11);
        misal  = (chk_funct3[1:0] == 2'b01 && chk_off[0]) ||
                 (chk_funct3[1:0] == 2'b10 && chk_off != 2'b00);
        err    = bad_f3 || misal;
    end

    assign mask      = lane_mask(funct3, off);
    assign wdata_sh  = wdata << {off, 3'b000};
    assign rdata_ext = load_extend(funct3, rdata, off);

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - RV32 load/store unit: request handshake, timed single memory access, response handshake
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int LAT  = 1,
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_err,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_raddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    lsu_state_t      state;
    logic [3:0]      count;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            valid_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;

    logic            req_err;
    logic [3:0]      mask;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rdata_ext;
    logic            access;
    logic            in_wait;

    lsu_align u_align (
        .chk_is_store (in_is_store),
        .chk_funct3   (in_funct3),
        .chk_off      (in_addr[1:0]),
        .err          (req_err),
        .funct3       (funct3),
        .off          (addr[1:0]),
        .wdata        (wdata),
        .rdata        (mem_rdata),
        .mask         (mask),
        .wdata_sh     (wdata_sh),
        .rdata_ext    (rdata_ext)
    );

    // Reset gates the memory port directly so a reset landing on the access cycle suppresses the write.
    assign in_wait   = (state == WAIT) && !reset;
    assign access    = in_wait && (count == 4'd0);
    assign mem_we    = access && is_store;
    assign mem_wmask = {4'b0000, mem_we ? mask : 4'b0000};
    assign mem_wdata = mem_we ? wdata_sh : '0;
    assign mem_waddr = in_wait ? {addr[XLEN-1:2], 2'b00} : '0;
    assign mem_raddr = mem_waddr;

    assign in_ready  = reset || (state == IDLE);
    assign out_valid = valid_q && !reset;
    assign out_err   = err_q && !reset;
    assign out_rdata = reset ? '0 : rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            is_store <= 1'b0;
            funct3   <= 3'd0;
            addr     <= '0;
            wdata    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_store <= in_is_store;
                        funct3   <= in_funct3;
                        addr     <= in_addr;
                        wdata    <= in_wdata;
                        rdata_q  <= '0;
                        if (req_err) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            count   <= LAT_M1;
                            err_q   <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        rdata_q <= is_store ? '0 : rdata_ext;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
